// File: rtl/spi_accel_master.sv
// SPI mode-0 master for the accelerometer: cmd byte, address byte, then 1..MAX_BYTES data bytes.
// Start/busy/done handshake, burst read/write, chip-select gap; all logic on vgaclk.
module spi_accel_master #(
    parameter int unsigned CLK_DIV   = 16,
    parameter int unsigned MAX_BYTES = 8,
    parameter int unsigned CS_GAP    = 4
) (
    input  logic                           vgaclk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           rw,
    input  logic [7:0]                     addr,
    input  logic [$clog2(MAX_BYTES+1)-1:0] len,
    input  logic [8*MAX_BYTES-1:0]         wdata,
    output logic                           busy,
    output logic                           done,
    output logic [8*MAX_BYTES-1:0]         rdata,
    input  logic                           MISO,
    output logic                           MOSI,
    output logic                           SS,
    output logic                           SPIclk
);

    localparam int unsigned LW   = $clog2(MAX_BYTES + 1);
    localparam int unsigned DW   = 8 * MAX_BYTES;
    localparam int unsigned TXW  = 8 * (2 + MAX_BYTES);
    localparam int unsigned HW   = $clog2(16 * (2 + MAX_BYTES) + CS_GAP + 1);
    localparam int unsigned DIVW = $clog2(CLK_DIV);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_e;

    state_e          state_q, state_d;
    logic [DIVW-1:0] div_q, div_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [HW-1:0]   hlast_q, hlast_d;
    logic            rw_q, rw_d;
    logic [TXW-1:0]  tx_q, tx_d;
    logic [7:0]      rx_q, rx_d;
    logic [DW-1:0]   shadow_q, shadow_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            mosi_q, mosi_d;
    logic            ss_q, ss_d;
    logic            sclk_q, sclk_d;

    logic            tick;
    logic [LW-1:0]   len_eff;
    logic [TXW-1:0]  tx_load;
    logic [HW-1:0]   bidx;

    assign busy   = busy_q;
    assign done   = done_q;
    assign rdata  = rdata_q;
    assign MOSI   = mosi_q;
    assign SS     = ss_q;
    assign SPIclk = sclk_q;

    // Clamp length to 1..MAX_BYTES and build the outgoing bit stream (unused data bytes are zero)
    always_comb begin
        if (len == '0) begin
            len_eff = LW'(1);
        end else if (len > LW'(MAX_BYTES)) begin
            len_eff = LW'(MAX_BYTES);
        end else begin
            len_eff = len;
        end
        tx_load = '0;
        tx_load[TXW-1 -: 8] = rw ? 8'h0B : 8'h0A;
        tx_load[TXW-9 -: 8] = addr;
        for (int k = 0; k < int'(MAX_BYTES); k++) begin
            if (!rw && (k < int'(len_eff))) begin
                tx_load[TXW-17-8*k -: 8] = wdata[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        hcnt_d   = hcnt_q;
        hlast_d  = hlast_q;
        rw_d     = rw_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        shadow_d = shadow_q;
        rdata_d  = rdata_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        mosi_d   = mosi_q;
        ss_d     = ss_q;
        sclk_d   = sclk_q;
        tick     = (div_q == DIVW'(CLK_DIV - 1));
        bidx     = (hcnt_q - HW'(32)) >> 4;

        if (state_q != S_IDLE) begin
            div_d = tick ? '0 : div_q + DIVW'(1);
        end

        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (done_q) begin
                    busy_d = 1'b0;
                end
                if (start && !busy_q) begin
                    rw_d     = rw;
                    tx_d     = tx_load;
                    hlast_d  = HW'(32) + (HW'(len_eff) << 4);
                    shadow_d = '0;
                    ss_d     = 1'b0;
                    mosi_d   = tx_load[TXW-1];
                    busy_d   = 1'b1;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    hcnt_d  = HW'(1);
                    state_d = S_SHIFT;
                end
            end
            // Odd count: falling edge drives next bit; even count: rising edge samples MISO
            S_SHIFT: begin
                if (tick) begin
                    hcnt_d = hcnt_q + HW'(1);
                    if (hcnt_q == hlast_q) begin
                        mosi_d  = 1'b0;
                        sclk_d  = 1'b0;
                        state_d = S_HOLD;
                    end else if (hcnt_q[0]) begin
                        sclk_d = 1'b0;
                        tx_d   = tx_q << 1;
                        mosi_d = tx_q[TXW-2];
                    end else begin
                        sclk_d = 1'b1;
                        if (hcnt_q >= HW'(32)) begin
                            rx_d = {rx_q[6:0], MISO};
                            if (hcnt_q[3:1] == 3'b111) begin
                                for (int k = 0; k < int'(MAX_BYTES); k++) begin
                                    if (bidx == HW'(k)) begin
                                        shadow_d[8*k +: 8] = {rx_q[6:0], MISO};
                                    end
                                end
                            end
                        end
                    end
                end
            end
            S_HOLD: begin
                if (tick) begin
                    ss_d    = 1'b1;
                    hcnt_d  = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (hcnt_q == HW'(CS_GAP - 1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                        if (rw_q) begin
                            rdata_d = shadow_q;
                        end
                    end else begin
                        hcnt_d = hcnt_q + HW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            hcnt_q   <= '0;
            hlast_q  <= '0;
            rw_q     <= 1'b0;
            tx_q     <= '0;
            rx_q     <= '0;
            shadow_q <= '0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mosi_q   <= 1'b0;
            ss_q     <= 1'b1;
            sclk_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            hcnt_q   <= hcnt_d;
            hlast_q  <= hlast_d;
            rw_q     <= rw_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            shadow_q <= shadow_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            mosi_q   <= mosi_d;
            ss_q     <= ss_d;
            sclk_q   <= sclk_d;
        end
    end

endmodule

// File: tb/tb_spi_accel_master.sv
// Bench for spi_accel_master: half-period-indexed reference model, pin-level slave,
// directed scenarios plus randomized transactions.
module tb_spi_accel_master;

    localparam int unsigned CLK_DIV   = 16;
    localparam int unsigned MAX_BYTES = 8;
    localparam int unsigned CS_GAP    = 4;
    localparam int unsigned LW        = $clog2(MAX_BYTES + 1);
    localparam int unsigned DW        = 8 * MAX_BYTES;
    localparam int unsigned NB        = MAX_BYTES + 2;

    logic          vgaclk = 1'b0;
    logic          rst_n  = 1'b1;
    logic          start  = 1'b0;
    logic          rw     = 1'b0;
    logic [7:0]    addr   = '0;
    logic [LW-1:0] len    = '0;
    logic [DW-1:0] wdata  = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] rdata;
    logic          MISO   = 1'b0;
    logic          MOSI;
    logic          SS;
    logic          SPIclk;

    spi_accel_master #(
        .CLK_DIV  (CLK_DIV),
        .MAX_BYTES(MAX_BYTES),
        .CS_GAP   (CS_GAP)
    ) dut (
        .vgaclk(vgaclk),
        .rst_n (rst_n),
        .start (start),
        .rw    (rw),
        .addr  (addr),
        .len   (len),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .rdata (rdata),
        .MISO  (MISO),
        .MOSI  (MOSI),
        .SS    (SS),
        .SPIclk(SPIclk)
    );

    always #5 vgaclk = ~vgaclk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pin-level slave: shifts sl_bytes out MSB first, captures MOSI on rising SPIclk
    logic [7:0] sl_bytes [NB];
    int         s_k    = 0;
    int         s_rise = 0;
    logic [7:0] s_sh   = '0;
    logic [7:0] s_rx [$];
    logic       ss_p   = 1'b1;
    logic       clk_p  = 1'b0;

    function automatic logic sl_bit(input int k);
        logic [7:0] b;
        if (k >= 8 * int'(NB)) return 1'($urandom);
        b = sl_bytes[k/8];
        return b[7 - k%8];
    endfunction

    always @(SS or SPIclk) begin
        if (SS === 1'b1) begin
            MISO = 1'($urandom);
        end else if (ss_p) begin
            s_k    = 0;
            s_rise = 0;
            s_rx.delete();
            MISO   = sl_bit(0);
        end else if (clk_p && !SPIclk) begin
            s_k++;
            MISO = sl_bit(s_k);
        end else if (!clk_p && SPIclk) begin
            s_sh = {s_sh[6:0], MOSI};
            s_rise++;
            if (s_rise % 8 == 0) s_rx.push_back(s_sh);
        end
        ss_p  = SS;
        clk_p = SPIclk;
    end

    // Reference model: transaction is a sequence of half-periods of CLK_DIV cycles each
    int            m_busy = 0;
    int            m_c    = 0;
    int            m_n    = 0;
    int            m_b    = 0;
    int            m_len  = 0;
    logic          m_rw   = 1'b0;
    logic [7:0]    m_tx [NB];
    logic [DW-1:0] m_rd_pend = '0;
    logic [DW-1:0] m_rdata   = '0;
    int unsigned   ecount    = 0;

    function automatic logic mosi_exp(input int i);
        logic [7:0] b;
        if (i >= 8 * m_b) return 1'b0;
        b = m_tx[i/8];
        return b[7 - i%8];
    endfunction

    always @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  = 0;
            m_c     = 0;
            m_rdata = '0;
        end else begin
            ecount++;
            if (m_busy != 0) begin
                m_c++;
                if (m_c == m_n * int'(CLK_DIV) && m_rw) m_rdata = m_rd_pend;
                if (m_c > m_n * int'(CLK_DIV)) m_busy = 0;
            end else if (start) begin
                m_len = (len == '0) ? 1 : ((int'(len) > int'(MAX_BYTES)) ? int'(MAX_BYTES) : int'(len));
                m_rw  = rw;
                m_b   = 2 + m_len;
                m_n   = 2 + 16 * m_b + int'(CS_GAP);
                m_tx[0]   = rw ? 8'h0B : 8'h0A;
                m_tx[1]   = addr;
                m_rd_pend = '0;
                for (int k = 0; k < int'(MAX_BYTES); k++) begin
                    m_tx[2+k] = (!rw && k < m_len) ? wdata[8*k +: 8] : 8'h00;
                    if (k < m_len) m_rd_pend[8*k +: 8] = sl_bytes[2+k];
                end
                m_c    = 0;
                m_busy = 1;
            end
        end
    end

    logic [4:0] c_exp;
    int         c_h;

    always @(negedge vgaclk) begin
        if (m_busy == 0) begin
            c_exp = 5'b10000;
        end else begin
            c_h = m_c / int'(CLK_DIV);
            if (c_h <= 16 * m_b) begin
                c_exp = {1'b0, 1'(c_h % 2), mosi_exp(c_h / 2), 1'b1, 1'b0};
            end else if (c_h == 16 * m_b + 1) begin
                c_exp = 5'b00010;
            end else begin
                c_exp = {1'b1, 2'b00, 1'b1, (m_c == m_n * int'(CLK_DIV))};
            end
        end
        check("pins{SS,SPIclk,MOSI,busy,done}", 64'({SS, SPIclk, MOSI, busy, done}), 64'(c_exp));
        check("rdata", rdata, m_rdata);
    end

    task automatic randomize_slave();
        for (int k = 0; k < int'(NB); k++) sl_bytes[k] = 8'($urandom);
    endtask

    task automatic launch(input logic r, input logic [7:0] a, input logic [LW-1:0] l,
                          input logic [DW-1:0] wd, output int unsigned t0);
        @(negedge vgaclk);
        rw    = r;
        addr  = a;
        len   = l;
        wdata = wd;
        start = 1'b1;
        t0    = ecount;
        @(negedge vgaclk);
        start = 1'b0;
        rw    = 1'($urandom);
        addr  = 8'($urandom);
        len   = LW'($urandom);
        wdata = {$urandom, $urandom};
    endtask

    task automatic wait_done(input string name, output int unsigned t_done);
        int n;
        n      = 0;
        t_done = 0;
        while (n < 4000) begin
            @(negedge vgaclk);
            n++;
            if (done === 1'b1) begin
                t_done = ecount;
                break;
            end
        end
        if (t_done == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: done seen 0 times, expected 1 within 4000 cycles", name);
        end
        repeat (3) @(negedge vgaclk);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned   t0;
        int unsigned   td;
        int            nd;
        int            n;
        int            le;
        logic          r;
        logic [LW-1:0] l;
        logic [DW-1:0] wd;

        randomize_slave();
        #1 rst_n = 1'b0;
        repeat (4) @(negedge vgaclk);
        check("reset_pins", 64'({SS, SPIclk, MOSI, busy, done}), 64'h10);
        check("reset_rdata", rdata, 64'h0);
        rst_n = 1'b1;
        repeat (20) @(negedge vgaclk);
        check("idle_after_reset", 64'({SS, SPIclk, MOSI, busy, done}), 64'h10);

        // Burst read of 6 bytes with start pulsed every 100 cycles while busy
        randomize_slave();
        for (int k = 0; k < 6; k++) sl_bytes[2+k] = 8'(k + 1);
        launch(1'b1, 8'h0E, LW'(6), {$urandom, $urandom}, t0);
        nd = 0;
        td = 0;
        for (int i = 0; i < 2400; i++) begin
            @(negedge vgaclk);
            if (done === 1'b1) begin
                nd++;
                td = ecount;
            end
            start = (i % 100 == 50) && (i < 2050);
            rw    = 1'($urandom);
            len   = LW'($urandom);
        end
        start = 1'b0;
        check("burst_done_pulses", 64'(nd), 64'd1);
        check("burst_latency", 64'(td - t0), 64'd2145);
        check("burst_rdata", rdata, 64'h0000_0605_0403_0201);
        repeat (3) @(negedge vgaclk);

        // Single-byte write; rdata must keep the previous read
        wd = {$urandom, $urandom};
        wd[7:0] = 8'h02;
        launch(1'b0, 8'h2D, LW'(1), wd, t0);
        wait_done("write_done", td);
        check("write_edges", 64'(s_rise), 64'd24);
        check("write_bytes", 64'(s_rx.size()), 64'd3);
        if (s_rx.size() == 3) check("write_mosi", 64'({s_rx[0], s_rx[1], s_rx[2]}), 64'h0A2D02);
        check("write_latency", 64'(td - t0), 64'd865);
        check("write_rdata_kept", rdata, 64'h0000_0605_0403_0201);

        // Length boundaries
        launch(1'b0, 8'($urandom), LW'(0), {$urandom, $urandom}, t0);
        wait_done("len0_done", td);
        check("len0_edges", 64'(s_rise), 64'd24);
        randomize_slave();
        launch(1'b1, 8'($urandom), LW'(15), {$urandom, $urandom}, t0);
        wait_done("len15_done", td);
        check("len15_edges", 64'(s_rise), 64'd80);
        check("len15_latency", 64'(td - t0), 64'(16 * (2 + 16 * 10 + 4) + 1));

        // Reset in the middle of a read
        randomize_slave();
        launch(1'b1, 8'h08, LW'(4), {$urandom, $urandom}, t0);
        n = 0;
        while (s_rise < 10 && n < 1000) begin
            @(negedge vgaclk);
            n++;
        end
        check("midreset_bit10", 64'(s_rise), 64'd10);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_pins", 64'({SS, SPIclk, MOSI, busy, done}), 64'h10);
        check("midreset_rdata", rdata, 64'h0);
        repeat (3) @(negedge vgaclk);
        rst_n = 1'b1;
        nd = 0;
        repeat (300) begin
            @(negedge vgaclk);
            if (done === 1'b1) nd++;
        end
        check("midreset_no_done", 64'(nd), 64'd0);

        // Randomized transactions
        for (int i = 0; i < 12; i++) begin
            randomize_slave();
            r  = 1'($urandom);
            l  = LW'($urandom_range(0, 15));
            le = (l == '0) ? 1 : ((int'(l) > int'(MAX_BYTES)) ? int'(MAX_BYTES) : int'(l));
            launch(r, 8'($urandom), l, {$urandom, $urandom}, t0);
            wait_done("rand_done", td);
            check("rand_edges", 64'(s_rise), 64'(8 * (2 + le)));
            check("rand_latency", 64'(td - t0), 64'(int'(CLK_DIV) * (2 + 16 * (2 + le) + int'(CS_GAP)) + 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
